// File: rtl/mfp_ahb_rojobot_if_pkg.sv
// Shared register map and AHB encodings for the rojobot AHB-Lite interface.
// Optional feature macro: ROJOBOT_MISS_CNT_EN (missed-update counter).
package mfp_ahb_rojobot_if_pkg;

    localparam int ROJO_OFFS_INFO   = 0;
    localparam int ROJO_OFFS_MOTCTL = 1;
    localparam int ROJO_OFFS_UPDT   = 2;
    localparam int ROJO_OFFS_ACK    = 3;
    localparam int ROJO_OFFS_CFG    = 4;
    localparam int ROJO_OFFS_MISS   = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    function automatic logic trans_valid(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/rojobot_upd_flag.sv
// Update-strobe edge detector, sticky CPU-acknowledged flag (set wins over ACK)
// and, under ROJOBOT_MISS_CNT_EN, a saturating missed-update counter.
module rojobot_upd_flag
    import mfp_ahb_rojobot_if_pkg::*;
#(
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_sysregs_i,
    input  logic              ack_clr_i,
    input  logic              miss_clr_i,
    output logic              upd_rise_o,
    output logic              flag_o,
    output logic [MISS_W-1:0] miss_cnt_o
);

    logic upd_q;
    logic flag_q;

    // A strobe held high for several cycles yields a single rise.
    assign upd_rise_o = upd_sysregs_i & ~upd_q;
    assign flag_o     = flag_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            upd_q <= upd_sysregs_i;
            if (upd_rise_o) begin
                flag_q <= 1'b1;
            end else if (ack_clr_i) begin
                flag_q <= 1'b0;
            end
        end
    end

`ifdef ROJOBOT_MISS_CNT_EN
    logic [MISS_W-1:0] miss_q;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (miss_clr_i) begin
            miss_q <= '0;
        end else if (upd_rise_o && flag_q && (miss_q != '1)) begin
            miss_q <= miss_q + MISS_W'(1);
        end
    end

    assign miss_cnt_o = miss_q;
`else
    logic unused_miss_clr;
    assign unused_miss_clr = miss_clr_i;
    assign miss_cnt_o      = '0;
`endif

endmodule

// File: rtl/mfp_ahb_rojobot_if.sv
// Zero-wait-state AHB-Lite slave exposing rojobot31 registers to the CPU.
// Optional feature macro: ROJOBOT_MISS_CNT_EN (missed-update counter at offset 0x14).
module mfp_ahb_rojobot_if
    import mfp_ahb_rojobot_if_pkg::*;
#(
    parameter int OFFS_W = 3,
    parameter int MISS_W = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic [7:0]  LocX_reg,
    input  logic [7:0]  LocY_reg,
    input  logic [7:0]  Sensors_reg,
    input  logic [7:0]  BotInfo_reg,
    input  logic        upd_sysregs,
    output logic [7:0]  MotCtl_in,
    output logic [7:0]  Bot_Config_reg,
    output logic        IO_BotUpdt
);

    logic              valid_q;
    logic              we_q;
    logic [OFFS_W-1:0] offs_q;
    logic [7:0]        motctl_q, motctl_d;
    logic [7:0]        cfg_q, cfg_d;
    logic [31:0]       snap_q;
    logic [31:0]       hrdata_q, rdata_d;

    logic              addr_valid;
    logic              rd_req;
    logic [OFFS_W-1:0] addr_offs;
    logic              wr_en;
    logic              ack_clr;
    logic              miss_clr;
    logic              upd_rise;
    logic              upd_flag;
    logic [MISS_W-1:0] miss_cnt;

    logic unused_bus;
    assign unused_bus = ^{HADDR[31:OFFS_W+2], HADDR[1:0], HWDATA[31:8]};

    assign addr_valid = HSEL && trans_valid(HTRANS);
    assign rd_req     = addr_valid && !HWRITE;
    assign addr_offs  = HADDR[OFFS_W+1:2];

    assign wr_en    = valid_q && we_q;
    assign ack_clr  = wr_en && (offs_q == OFFS_W'(ROJO_OFFS_ACK)) && HWDATA[0];
    assign miss_clr = wr_en && (offs_q == OFFS_W'(ROJO_OFFS_MISS));

    rojobot_upd_flag #(
        .MISS_W (MISS_W)
    ) u_upd_flag (
        .clk           (HCLK),
        .rst_n         (HRESETn),
        .upd_sysregs_i (upd_sysregs),
        .ack_clr_i     (ack_clr),
        .miss_clr_i    (miss_clr),
        .upd_rise_o    (upd_rise),
        .flag_o        (upd_flag),
        .miss_cnt_o    (miss_cnt)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        motctl_d = motctl_q;
        cfg_d    = cfg_q;
        if (wr_en && (offs_q == OFFS_W'(ROJO_OFFS_MOTCTL))) begin
            motctl_d = HWDATA[7:0];
        end
        if (wr_en && (offs_q == OFFS_W'(ROJO_OFFS_CFG))) begin
            cfg_d = HWDATA[7:0];
        end

        // Control readback uses next-state values so a read right after a write sees the new data.
        rdata_d = '0;
        case (addr_offs)
            OFFS_W'(ROJO_OFFS_INFO):   rdata_d = snap_q;
            OFFS_W'(ROJO_OFFS_MOTCTL): rdata_d = {24'b0, motctl_d};
            OFFS_W'(ROJO_OFFS_UPDT):   rdata_d = {31'b0, upd_flag};
            OFFS_W'(ROJO_OFFS_CFG):    rdata_d = {24'b0, cfg_d};
            OFFS_W'(ROJO_OFFS_MISS):   rdata_d = 32'(miss_cnt);
            default:                   rdata_d = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            offs_q   <= '0;
            motctl_q <= '0;
            cfg_q    <= '0;
            snap_q   <= '0;
            hrdata_q <= '0;
        end else begin
            valid_q  <= addr_valid;
            we_q     <= HWRITE;
            offs_q   <= addr_offs;
            motctl_q <= motctl_d;
            cfg_q    <= cfg_d;
            if (rd_req) begin
                hrdata_q <= rdata_d;
            end
            if (upd_rise) begin
                snap_q <= {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg};
            end
        end
    end

    assign HRDATA         = hrdata_q;
    assign MotCtl_in      = motctl_q;
    assign Bot_Config_reg = cfg_q;
    assign IO_BotUpdt     = upd_flag;

endmodule

// File: tb/tb_mfp_ahb_rojobot_if.sv
// Scoreboard bench for mfp_ahb_rojobot_if: reference model pushes expected read data,
// a monitor pops and compares in each read data phase and checks control outputs every cycle.
module tb_mfp_ahb_rojobot_if;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [7:0]  LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg;
    logic        upd_sysregs;
    logic [7:0]  MotCtl_in;
    logic [7:0]  Bot_Config_reg;
    logic        IO_BotUpdt;

    int checks = 0;
    int errors = 0;

    mfp_ahb_rojobot_if dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .HSEL           (HSEL),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HADDR          (HADDR),
        .HWDATA         (HWDATA),
        .HRDATA         (HRDATA),
        .LocX_reg       (LocX_reg),
        .LocY_reg       (LocY_reg),
        .Sensors_reg    (Sensors_reg),
        .BotInfo_reg    (BotInfo_reg),
        .upd_sysregs    (upd_sysregs),
        .MotCtl_in      (MotCtl_in),
        .Bot_Config_reg (Bot_Config_reg),
        .IO_BotUpdt     (IO_BotUpdt)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register-map semantics evaluated once per clock edge.
    logic [31:0] sb[$];
    bit   [7:0]  m_motctl, m_cfg;
    bit          m_flag, m_upd_prev, m_pend;
    bit   [2:0]  m_pend_offs;
    bit   [31:0] m_snap;
    int unsigned m_miss;

    task automatic model_reset();
        m_motctl = 0; m_cfg = 0; m_flag = 0; m_upd_prev = 0;
        m_pend = 0; m_pend_offs = 0; m_snap = 0; m_miss = 0;
        sb.delete();
    endtask

    task automatic model_edge();
        bit rise, ack, mclr;
        bit [7:0] nm, nc;
        bit [31:0] rexp;
        if (!HRESETn) begin
            model_reset();
            return;
        end
        rise = upd_sysregs && !m_upd_prev;
        nm = m_motctl; nc = m_cfg; ack = 0; mclr = 0;
        if (m_pend) begin
            case (m_pend_offs)
                3'd1: nm = HWDATA[7:0];
                3'd3: ack = HWDATA[0];
                3'd4: nc = HWDATA[7:0];
                3'd5: mclr = 1;
                default: ;
            endcase
        end
        if (HSEL && HTRANS[1] && !HWRITE) begin
            case (HADDR[4:2])
                3'd0:    rexp = m_snap;
                3'd1:    rexp = {24'b0, nm};
                3'd2:    rexp = {31'b0, m_flag};
                3'd4:    rexp = {24'b0, nc};
                3'd5:    rexp = m_miss;
                default: rexp = 0;
            endcase
            sb.push_back(rexp);
        end
`ifdef ROJOBOT_MISS_CNT_EN
        if (mclr) m_miss = 0;
        else if (rise && m_flag && m_miss < 255) m_miss = m_miss + 1;
`endif
        if (rise) m_flag = 1;
        else if (ack) m_flag = 0;
        if (rise) m_snap = {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg};
        m_motctl = nm; m_cfg = nc;
        m_upd_prev = upd_sysregs;
        m_pend = HSEL && HTRANS[1] && HWRITE;
        m_pend_offs = HADDR[4:2];
    endtask

    // Monitor: detects read data phases from the bus itself and pops the scoreboard.
    logic rd_dphase;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rd_dphase <= 1'b0;
        else          rd_dphase <= HSEL && HTRANS[1] && !HWRITE;
    end

    always @(negedge HCLK) begin
        if (HRESETn) begin
            check("motctl", {24'b0, MotCtl_in}, {24'b0, m_motctl});
            check("cfg", {24'b0, Bot_Config_reg}, {24'b0, m_cfg});
            check("updt_flag", {31'b0, IO_BotUpdt}, {31'b0, m_flag});
            if (rd_dphase) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: read data phase with no expected value at %0t", $time);
                end else begin
                    check("hrdata", HRDATA, sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #2;
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit sel = 1'b1, input logic [1:0] tr = 2'b10);
        HSEL = sel; HTRANS = tr; HWRITE = w; HADDR = a;
        tick();
        HWDATA = w ? d : $urandom;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'($urandom); HADDR = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hrdata"}, HRDATA, 32'h0);
        check({tag, "_motctl"}, {24'b0, MotCtl_in}, 32'h0);
        check({tag, "_cfg"}, {24'b0, Bot_Config_reg}, 32'h0);
        check({tag, "_flag"}, {31'b0, IO_BotUpdt}, 32'h0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        HRESETn = 1'b0; HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HWDATA = 0;
        LocX_reg = 0; LocY_reg = 0; Sensors_reg = 0; BotInfo_reg = 0; upd_sysregs = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();

        // Reset in the middle of a write data phase discards the write.
        xfer(1'b1, 32'h04, 32'hAA);
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();
        check("midreset_motctl_after", {24'b0, MotCtl_in}, 32'h0);

        // Write then read motor control.
        xfer(1'b1, 32'h04, 32'h000000A5);
        xfer(1'b0, 32'h04, 32'h0);
        check("motctl_a5", {24'b0, MotCtl_in}, 32'hA5);
        check("rd_motctl_a5", HRDATA, 32'hA5);
        tick();

        // Update strobe held high for 3 cycles: one update, coherent snapshot.
        LocX_reg = 8'h12; LocY_reg = 8'h34; Sensors_reg = 8'h56; BotInfo_reg = 8'h78;
        upd_sysregs = 1'b1;
        tick();
        check("flag_after_rise", {31'b0, IO_BotUpdt}, 32'h1);
        LocX_reg = 8'h9A; LocY_reg = 8'hBC; Sensors_reg = 8'hDE; BotInfo_reg = 8'hF0;
        repeat (2) tick();
        upd_sysregs = 1'b0;
        tick();
        xfer(1'b0, 32'h00, 32'h0);
        check("rd_info", HRDATA, 32'h12345678);
        xfer(1'b0, 32'h08, 32'h0);
        check("rd_updt", HRDATA, 32'h1);
        tick();

        // ACK write coinciding with an update rise: set wins.
        xfer(1'b1, 32'h0C, 32'h1);
        upd_sysregs = 1'b1;
        tick();
        check("ack_vs_rise_flag", {31'b0, IO_BotUpdt}, 32'h1);
        upd_sysregs = 1'b0;
        tick();
        xfer(1'b1, 32'h0C, 32'h1);
        tick();
        check("ack_alone_flag", {31'b0, IO_BotUpdt}, 32'h0);

        // Back-to-back write then read of bot config.
        xfer(1'b1, 32'h10, 32'h0000003C);
        xfer(1'b0, 32'h10, 32'h0);
        check("cfg_3c", {24'b0, Bot_Config_reg}, 32'h3C);
        check("rd_cfg_3c", HRDATA, 32'h3C);
        tick();

        // 300 updates without ACK: counter saturates (or reads 0 without the feature).
        xfer(1'b1, 32'h14, 32'h0);
        for (int i = 0; i < 300; i++) begin
            upd_sysregs = 1'b1; tick();
            upd_sysregs = 1'b0; tick();
        end
        xfer(1'b0, 32'h14, 32'h0);
`ifdef ROJOBOT_MISS_CNT_EN
        check("rd_miss_sat", HRDATA, 32'hFF);
`else
        check("rd_miss_off", HRDATA, 32'h0);
`endif
        xfer(1'b1, 32'h14, 32'h0);
        tick();
        xfer(1'b0, 32'h14, 32'h0);
        check("rd_miss_cleared", HRDATA, 32'h0);
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            LocX_reg = $urandom; LocY_reg = $urandom; Sensors_reg = $urandom; BotInfo_reg = $urandom;
            upd_sysregs = ($urandom_range(0, 2) == 0);
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       tick();
                1:       xfer(1'($urandom), a, $urandom, 1'($urandom), 2'($urandom));
                default: xfer(1'($urandom), a, $urandom, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10);
            endcase
        end
        upd_sysregs = 1'b0;
        repeat (4) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
